// File: rtl/exu_issue_ctrl.sv
// Execute-stage issue controller: owns the ID->EX slot handshake, inserts
// load-use bubbles, holds mul/div ops in EX for their fixed latency and
// kills younger work when a taken redirect leaves EX.
module exu_issue_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_src1_is_reg,
    input  logic        id_src2_is_reg,
    input  logic [4:0]  id_rd,
    input  logic        id_need_to_wb,
    input  logic        id_is_load,
    input  logic        id_is_muldiv,
    input  logic        id_is_div,
    input  logic        redirect_valid,
    input  logic        mem_ready,
    output logic        ex_load_en,
    output logic        ex_pipeval,
    output logic        ex_fire,
    output logic        flush_front,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic [31:0] bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_READY,
        ST_BUSY
    } slot_state_t;

    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] op_lat;
    logic [4:0]       ex_rd_q;
    logic             ex_is_load_q;
    logic             ex_need_to_wb_q;
    logic             muldiv_start_q;
    logic [31:0]      bubble_cnt_q;
    logic             hazard;
    logic             src_match;
    logic             bubble_inc;

    // Slot status, load-use detection and the ID handshake
    always_comb begin
        src_match   = (id_src1_is_reg && (id_rs1 == ex_rd_q)) ||
                      (id_src2_is_reg && (id_rs2 == ex_rd_q));
        hazard      = (state_q != ST_EMPTY) && ex_is_load_q && ex_need_to_wb_q &&
                      (ex_rd_q != 5'd0) && src_match;
        ex_pipeval  = (state_q != ST_EMPTY);
        muldiv_busy = (state_q == ST_BUSY);
        ex_fire     = (state_q == ST_READY) && mem_ready;
        flush_front = ex_fire && redirect_valid;
        id_ready    = ((state_q == ST_EMPTY) || ex_fire) && !hazard && !flush_front;
        ex_load_en  = id_valid && id_ready;
        bubble_inc  = ex_fire && hazard && id_valid && !flush_front;
        op_lat      = id_is_div ? DIV_LAT_C : MUL_LAT_C;
    end

    // Next slot state: a new accept wins, otherwise count down or drain
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ex_load_en) begin
            if (id_is_muldiv && (op_lat > CNT_ONE)) begin
                state_d = ST_BUSY;
                cnt_d   = op_lat - CNT_ONE;
            end else begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_BUSY: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (ex_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State register, latched hazard payload, mul/div start pulse and bubble counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_EMPTY;
            cnt_q           <= '0;
            ex_rd_q         <= 5'd0;
            ex_is_load_q    <= 1'b0;
            ex_need_to_wb_q <= 1'b0;
            muldiv_start_q  <= 1'b0;
            bubble_cnt_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            muldiv_start_q <= ex_load_en && id_is_muldiv;
            if (ex_load_en) begin
                ex_rd_q         <= id_rd;
                ex_is_load_q    <= id_is_load;
                ex_need_to_wb_q <= id_need_to_wb;
            end
            if (bubble_inc && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign muldiv_start = muldiv_start_q;
    assign bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Self-checking bench for exu_issue_ctrl: a driver applies directed and random
// traffic, a reference model predicts every output per cycle into a queue, and
// a monitor pops and compares on the falling edge.
module tb_exu_issue_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 34;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       s1;
        logic       s2;
        logic       wb;
        logic       ld;
        logic       md;
        logic       dv;
    } op_t;

    typedef struct packed {
        logic        id_ready;
        logic        load_en;
        logic        pipeval;
        logic        fire;
        logic        flush;
        logic        start;
        logic        busy;
        logic [31:0] bubbles;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_src1_is_reg;
    logic        id_src2_is_reg;
    logic [4:0]  id_rd;
    logic        id_need_to_wb;
    logic        id_is_load;
    logic        id_is_muldiv;
    logic        id_is_div;
    logic        redirect_valid;
    logic        mem_ready;
    logic        ex_load_en;
    logic        ex_pipeval;
    logic        ex_fire;
    logic        flush_front;
    logic        muldiv_start;
    logic        muldiv_busy;
    logic [31:0] bubble_cnt;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: an occupied slot plus how many more cycles it must wait
    bit          m_full;
    int          m_wait;
    op_t         m_op;
    bit          m_start;
    longint      m_bubbles;
    bit          m_accepted;

    exu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_src1_is_reg(id_src1_is_reg), .id_src2_is_reg(id_src2_is_reg),
        .id_rd(id_rd), .id_need_to_wb(id_need_to_wb),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .id_is_div(id_is_div),
        .redirect_valid(redirect_valid), .mem_ready(mem_ready),
        .ex_load_en(ex_load_en), .ex_pipeval(ex_pipeval), .ex_fire(ex_fire),
        .flush_front(flush_front), .muldiv_start(muldiv_start),
        .muldiv_busy(muldiv_busy), .bubble_cnt(bubble_cnt)
    );

    always #5 clock = ~clock;

    function automatic op_t mk_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic wb, input logic ld, input logic md, input logic dv);
        op_t o;
        o.rd = rd; o.rs1 = rs1; o.rs2 = rs2;
        o.s1 = 1'b1; o.s2 = 1'b1;
        o.wb = wb; o.ld = ld; o.md = md; o.dv = dv;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int kind;
        kind  = $urandom_range(0, 99);
        o.rd  = 5'($urandom_range(0, 3));
        o.rs1 = 5'($urandom_range(0, 3));
        o.rs2 = 5'($urandom_range(0, 3));
        o.s1  = 1'($urandom_range(0, 1));
        o.s2  = 1'($urandom_range(0, 1));
        o.wb  = ($urandom_range(0, 9) != 0);
        o.ld  = (kind < 30);
        o.md  = (kind >= 85);
        o.dv  = (kind >= 96) ? 1'b1 : 1'($urandom_range(0, 1) & (kind < 85));
        return o;
    endfunction

    // Drive one cycle of inputs, predict that cycle's outputs, advance the model
    task automatic applyStimulus(input logic rst_n_v, input logic valid, input op_t op,
                                 input logic redir, input logic mrdy);
        exp_t e;
        bit fire, flush, haz, rdy, acc;
        int lat;
        @(posedge clock);
        #1;
        reset_n        = rst_n_v;
        id_valid       = valid;
        id_rs1         = op.rs1;
        id_rs2         = op.rs2;
        id_src1_is_reg = op.s1;
        id_src2_is_reg = op.s2;
        id_rd          = op.rd;
        id_need_to_wb  = op.wb;
        id_is_load     = op.ld;
        id_is_muldiv   = op.md;
        id_is_div      = op.dv;
        redirect_valid = redir;
        mem_ready      = mrdy;

        fire  = m_full && (m_wait == 0) && mrdy;
        flush = fire && redir;
        haz   = m_full && m_op.ld && m_op.wb && (m_op.rd != 0) &&
                ((op.s1 && op.rs1 == m_op.rd) || (op.s2 && op.rs2 == m_op.rd));
        rdy   = (!m_full || fire) && !haz && !flush;
        acc   = valid && rdy;

        e.id_ready = rdy;
        e.load_en  = acc;
        e.pipeval  = m_full;
        e.fire     = fire;
        e.flush    = flush;
        e.start    = m_start;
        e.busy     = m_full && (m_wait > 0);
        e.bubbles  = m_bubbles[31:0];
        exp_q.push_back(e);
        m_accepted = acc;

        if (!rst_n_v) begin
            m_full = 0; m_wait = 0; m_start = 0; m_bubbles = 0; m_op = '0;
        end else begin
            if (fire && haz && valid && !flush && m_bubbles < 64'hFFFF_FFFF)
                m_bubbles++;
            m_start = acc && op.md;
            if (acc) begin
                lat    = op.md ? (op.dv ? DIV_LAT : MUL_LAT) : 1;
                m_full = 1;
                m_wait = lat - 1;
                m_op   = op;
            end else if (fire) begin
                m_full = 0;
            end else if (m_wait > 0) begin
                m_wait--;
            end
        end
    endtask

    // Keep presenting one op until the model says it was accepted
    task automatic issueOp(input op_t op, input logic mrdy);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b1, op, 1'b0, mrdy);
            n++;
        end while (!m_accepted && n < 200);
        if (!m_accepted) begin
            errors++;
            $display("[TB] FAIL issue_timeout: op not accepted after %0d cycles, required acceptance", n);
        end
    endtask

    task automatic idleCycles(input int n, input logic mrdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, mrdy);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    // Monitor: compare every predicted cycle on the falling edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("id_ready",     {31'd0, id_ready},     {31'd0, e.id_ready});
                checkOutput("ex_load_en",   {31'd0, ex_load_en},   {31'd0, e.load_en});
                checkOutput("ex_pipeval",   {31'd0, ex_pipeval},   {31'd0, e.pipeval});
                checkOutput("ex_fire",      {31'd0, ex_fire},      {31'd0, e.fire});
                checkOutput("flush_front",  {31'd0, flush_front},  {31'd0, e.flush});
                checkOutput("muldiv_start", {31'd0, muldiv_start}, {31'd0, e.start});
                checkOutput("muldiv_busy",  {31'd0, muldiv_busy},  {31'd0, e.busy});
                checkOutput("bubble_cnt",   bubble_cnt,            e.bubbles);
            end
        end
    end

    initial begin : driver
        op_t br;
        reset_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_src1_is_reg = 1'b0; id_src2_is_reg = 1'b0; id_need_to_wb = 1'b0;
        id_is_load = 1'b0; id_is_muldiv = 1'b0; id_is_div = 1'b0;
        redirect_valid = 1'b0; mem_ready = 1'b1;
        m_full = 0; m_wait = 0; m_op = '0; m_start = 0; m_bubbles = 0; m_accepted = 0;
        repeat (2) @(posedge clock);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Back-to-back independent ALU ops
        issueOp(mk_op(5'd1, 5'd2, 5'd3, 1, 0, 0, 0), 1'b1);
        issueOp(mk_op(5'd4, 5'd2, 5'd3, 1, 0, 0, 0), 1'b1);
        issueOp(mk_op(5'd6, 5'd2, 5'd3, 1, 0, 0, 0), 1'b1);
        idleCycles(2, 1'b1);

        // Load-use bubble, then the same pattern through x0
        issueOp(mk_op(5'd5, 5'd1, 5'd1, 1, 1, 0, 0), 1'b1);
        issueOp(mk_op(5'd7, 5'd5, 5'd9, 1, 0, 0, 0), 1'b1);
        issueOp(mk_op(5'd0, 5'd1, 5'd1, 1, 1, 0, 0), 1'b1);
        issueOp(mk_op(5'd7, 5'd0, 5'd9, 1, 0, 0, 0), 1'b1);
        idleCycles(2, 1'b1);

        // Multiply, then divide with a younger op waiting behind it
        issueOp(mk_op(5'd3, 5'd1, 5'd2, 1, 0, 1, 0), 1'b1);
        idleCycles(4, 1'b1);
        issueOp(mk_op(5'd3, 5'd1, 5'd2, 1, 0, 1, 1), 1'b1);
        issueOp(mk_op(5'd8, 5'd3, 5'd2, 1, 0, 0, 0), 1'b1);
        idleCycles(2, 1'b1);

        // Taken redirect while decode presents a younger op
        br = mk_op(5'd0, 5'd1, 5'd2, 0, 0, 0, 0);
        issueOp(br, 1'b1);
        applyStimulus(1'b1, 1'b1, mk_op(5'd9, 5'd1, 5'd1, 1, 0, 0, 0), 1'b1, 1'b1);
        idleCycles(2, 1'b1);

        // Reset while a divide counts down
        issueOp(mk_op(5'd3, 5'd1, 5'd2, 1, 0, 1, 1), 1'b1);
        idleCycles(13, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idleCycles(2, 1'b1);

        // MEM back-pressure for four cycles
        issueOp(mk_op(5'd1, 5'd2, 5'd3, 1, 0, 0, 0), 1'b1);
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b1, mk_op(5'd2, 5'd4, 5'd4, 1, 0, 0, 0), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, mk_op(5'd2, 5'd4, 5'd4, 1, 0, 0, 0), 1'b0, 1'b1);
        idleCycles(2, 1'b1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(0, 399) != 0),
                          ($urandom_range(0, 9) < 7),
                          rand_op(),
                          ($urandom_range(0, 99) < 15),
                          ($urandom_range(0, 9) < 8));
        end

        @(negedge clock);
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
